// File: rtl/mem_wb_min_reg_pkg.sv
// Shared types and constants for the MEM/WB register and SAD min tracker.
package mem_wb_min_reg_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;

    // Wide enough for any supported DATA_W; users slice the low bits.
    localparam logic [63:0] BEST_RESET = '1;

    typedef enum logic {
        EMPTY    = 1'b0,
        TRACKING = 1'b1
    } trk_state_e;

endpackage

// File: rtl/mem_wb_min_reg_min_tracker.sv
// Running-minimum tracker for SAD search; acts only on W-stage retire.
module min_tracker
    import mem_wb_min_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_i,
    input  logic              sad_update_i,
    input  logic              min_clear_i,
    input  logic [DATA_W-1:0] sad_i,
    input  logic [DATA_W-1:0] sad_x_i,
    input  logic [DATA_W-1:0] sad_y_i,
    input  logic [DATA_W-1:0] min_i,
    input  logic [DATA_W-1:0] min_x_i,
    input  logic [DATA_W-1:0] min_y_i,
    output logic [DATA_W-1:0] best_o,
    output logic [DATA_W-1:0] best_x_o,
    output logic [DATA_W-1:0] best_y_o,
    output logic              best_valid_o,
    output logic [CNT_W-1:0]  cand_count_o
);

    localparam logic [DATA_W-1:0] BEST_INIT = BEST_RESET[DATA_W-1:0];

    trk_state_e        state_q, state_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [DATA_W-1:0] best_x_q, best_x_d;
    logic [DATA_W-1:0] best_y_q, best_y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        best_d   = best_q;
        best_x_d = best_x_q;
        best_y_d = best_y_q;
        cnt_d    = cnt_q;
        if (retire_i) begin
            if (min_clear_i) begin
                state_d  = EMPTY;
                best_d   = BEST_INIT;
                best_x_d = '0;
                best_y_d = '0;
                cnt_d    = '0;
            end
            if (sad_update_i) begin
                // First candidate after a clear bypasses the comparator.
                if (min_clear_i || state_q == EMPTY) begin
                    state_d  = TRACKING;
                    best_d   = sad_i;
                    best_x_d = sad_x_i;
                    best_y_d = sad_y_i;
                    cnt_d    = CNT_W'(1);
                end else begin
                    best_d   = min_i;
                    best_x_d = min_x_i;
                    best_y_d = min_y_i;
                    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            best_q   <= BEST_INIT;
            best_x_q <= '0;
            best_y_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            best_q   <= best_d;
            best_x_q <= best_x_d;
            best_y_q <= best_y_d;
            cnt_q    <= cnt_d;
        end
    end

    assign best_o       = best_q;
    assign best_x_o     = best_x_q;
    assign best_y_o     = best_y_q;
    assign best_valid_o = (state_q == TRACKING);
    assign cand_count_o = cnt_q;

endmodule

// File: rtl/mem_wb_min_reg.sv
// MEM/WB pipeline register with SAD running-minimum tracker.
// Optional MEMWB_PERF_CNT_EN adds RetireCount/BubbleCount outputs.
module mem_wb_min_reg
    import mem_wb_min_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic                  MemtoRegM,
    input  logic                  jalM,
    input  logic [DATA_W-1:0]     ALUResultM,
    input  logic [DATA_W-1:0]     MemReadDataM,
    input  logic [DATA_W-1:0]     PCPlus4M,
    input  logic                  SadUpdateM,
    input  logic                  MinClearM,
    input  logic [DATA_W-1:0]     SadM,
    input  logic [DATA_W-1:0]     SadXM,
    input  logic [DATA_W-1:0]     SadYM,
    input  logic [DATA_W-1:0]     MinIn,
    input  logic [DATA_W-1:0]     MinXIn,
    input  logic [DATA_W-1:0]     MinYIn,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  jalW,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic [DATA_W-1:0]     ALUResultW,
    output logic [DATA_W-1:0]     MemReadDataW,
    output logic [DATA_W-1:0]     PCPlus4W,
    output logic [DATA_W-1:0]     SadW,
    output logic [DATA_W-1:0]     SadXW,
    output logic [DATA_W-1:0]     SadYW,
    output logic [DATA_W-1:0]     BestW,
    output logic [DATA_W-1:0]     BestXW,
    output logic [DATA_W-1:0]     BestYW,
    output logic                  BestValid,
`ifdef MEMWB_PERF_CNT_EN
    output logic [CNT_W-1:0]      CandCount,
    output logic [31:0]           RetireCount,
    output logic [31:0]           BubbleCount
`else
    output logic [CNT_W-1:0]      CandCount
`endif
);

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  jal_q, jal_d;
    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0]     pc_plus4_q, pc_plus4_d;
    logic                  sad_update_q, sad_update_d;
    logic                  min_clear_q, min_clear_d;
    logic [DATA_W-1:0]     sad_q, sad_d;
    logic [DATA_W-1:0]     sad_x_q, sad_x_d;
    logic [DATA_W-1:0]     sad_y_q, sad_y_d;
    logic                  retire;

    // Flush still lets the instruction leaving W retire into the tracker.
    assign retire = valid_q && !StallW;

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        mem_to_reg_d = mem_to_reg_q;
        jal_d        = jal_q;
        alu_result_d = alu_result_q;
        mem_rdata_d  = mem_rdata_q;
        pc_plus4_d   = pc_plus4_q;
        sad_update_d = sad_update_q;
        min_clear_d  = min_clear_q;
        sad_d        = sad_q;
        sad_x_d      = sad_x_q;
        sad_y_d      = sad_y_q;
        if (FlushW) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            write_reg_d  = '0;
            mem_to_reg_d = 1'b0;
            jal_d        = 1'b0;
            alu_result_d = '0;
            mem_rdata_d  = '0;
            pc_plus4_d   = '0;
            sad_update_d = 1'b0;
            min_clear_d  = 1'b0;
            sad_d        = '0;
            sad_x_d      = '0;
            sad_y_d      = '0;
        end else if (!StallW) begin
            valid_d      = ValidM;
            reg_write_d  = RegWriteM;
            write_reg_d  = WriteRegM;
            mem_to_reg_d = MemtoRegM;
            jal_d        = jalM;
            alu_result_d = ALUResultM;
            mem_rdata_d  = MemReadDataM;
            pc_plus4_d   = PCPlus4M;
            sad_update_d = SadUpdateM;
            min_clear_d  = MinClearM;
            sad_d        = SadM;
            sad_x_d      = SadXM;
            sad_y_d      = SadYM;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            mem_to_reg_q <= 1'b0;
            jal_q        <= 1'b0;
            alu_result_q <= '0;
            mem_rdata_q  <= '0;
            pc_plus4_q   <= '0;
            sad_update_q <= 1'b0;
            min_clear_q  <= 1'b0;
            sad_q        <= '0;
            sad_x_q      <= '0;
            sad_y_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            mem_to_reg_q <= mem_to_reg_d;
            jal_q        <= jal_d;
            alu_result_q <= alu_result_d;
            mem_rdata_q  <= mem_rdata_d;
            pc_plus4_q   <= pc_plus4_d;
            sad_update_q <= sad_update_d;
            min_clear_q  <= min_clear_d;
            sad_q        <= sad_d;
            sad_x_q      <= sad_x_d;
            sad_y_q      <= sad_y_d;
        end
    end

    assign ValidW       = valid_q;
    assign RegWriteW    = reg_write_q;
    assign WriteRegW    = write_reg_q;
    assign MemtoRegW    = mem_to_reg_q;
    assign jalW         = jal_q;
    assign ALUResultW   = alu_result_q;
    assign MemReadDataW = mem_rdata_q;
    assign PCPlus4W     = pc_plus4_q;
    assign SadW         = sad_q;
    assign SadXW        = sad_x_q;
    assign SadYW        = sad_y_q;

    min_tracker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_trk (
        .clk          (Clk),
        .rst          (Rst),
        .retire_i     (retire),
        .sad_update_i (sad_update_q),
        .min_clear_i  (min_clear_q),
        .sad_i        (sad_q),
        .sad_x_i      (sad_x_q),
        .sad_y_i      (sad_y_q),
        .min_i        (MinIn),
        .min_x_i      (MinXIn),
        .min_y_i      (MinYIn),
        .best_o       (BestW),
        .best_x_o     (BestXW),
        .best_y_o     (BestYW),
        .best_valid_o (BestValid),
        .cand_count_o (CandCount)
    );

`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (retire) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
        if (FlushW || (!ValidM && !StallW)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign RetireCount = retire_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`endif

endmodule
